// File: rtl/hdma_engine.sv
// HDMA block-copy engine: CPU-programmed source/destination, general or hblank-paced
// transfers of BLOCK_BYTES-sized blocks, two bus cycles (read, write) per byte.
module hdma_engine #(
    parameter int unsigned BLOCK_BYTES = 16,
    parameter logic [15:0] REG_BASE    = 16'hFF51,
    parameter logic [15:0] DST_BASE    = 16'h8000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] reg_addr,
    input  logic [7:0]  reg_wdata,
    input  logic        reg_re,
    input  logic        reg_we,
    output logic [7:0]  reg_rdata,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_wdata,
    output logic        dma_re,
    output logic        dma_we,
    input  logic [7:0]  dma_rdata,
    input  logic        hblank,
    output logic        cpu_mem_disable,
    output logic        busy
);
    localparam int unsigned CW = $clog2(BLOCK_BYTES);
    localparam logic [CW-1:0] LAST_BYTE = CW'(BLOCK_BYTES - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, HB_WAIT} state_t;

    state_t        state;
    logic [7:0]    src_hi;
    logic [3:0]    src_lo;
    logic [4:0]    dst_hi;
    logic [3:0]    dst_lo;
    logic [15:0]   src;
    logic [12:0]   dst_off;
    logic [CW-1:0] byte_cnt;
    logic [6:0]    blocks_left;
    logic          mode;
    logic          cancel;
    logic          hb_q;

    logic          sel_ctrl, ctrl_wr, cancel_req, hb_rise, last_byte;
    logic [15:0]   src_start, dst_addr, src_next;

    always_comb begin
        sel_ctrl   = (reg_addr == REG_BASE + 16'd4);
        ctrl_wr    = reg_we && sel_ctrl;
        cancel_req = ctrl_wr && !reg_wdata[7] && mode;
        hb_rise    = hblank && !hb_q;
        last_byte  = (byte_cnt == LAST_BYTE);
        src_start  = {src_hi, src_lo, 4'b0};
        src_next   = src + 16'd1;
        dst_addr   = DST_BASE | {3'b0, dst_off};
        reg_rdata  = (reg_re && sel_ctrl) ? {~busy, blocks_left} : 8'h00;
    end

    // Bus outputs are registered: every transition loads the values the new state drives.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= IDLE;
            src_hi          <= '0;
            src_lo          <= '0;
            dst_hi          <= '0;
            dst_lo          <= '0;
            src             <= '0;
            dst_off         <= '0;
            byte_cnt        <= '0;
            blocks_left     <= '1;
            mode            <= 1'b0;
            cancel          <= 1'b0;
            hb_q            <= 1'b0;
            dma_addr        <= '0;
            dma_wdata       <= '0;
            dma_re          <= 1'b0;
            dma_we          <= 1'b0;
            cpu_mem_disable <= 1'b0;
            busy            <= 1'b0;
        end else begin
            hb_q <= hblank;
            case (state)
                IDLE: begin
                    if (reg_we && reg_addr == REG_BASE)         src_hi <= reg_wdata;
                    if (reg_we && reg_addr == REG_BASE + 16'd1) src_lo <= reg_wdata[7:4];
                    if (reg_we && reg_addr == REG_BASE + 16'd2) dst_hi <= reg_wdata[4:0];
                    if (reg_we && reg_addr == REG_BASE + 16'd3) dst_lo <= reg_wdata[7:4];
                    if (ctrl_wr) begin
                        blocks_left <= reg_wdata[6:0];
                        mode        <= reg_wdata[7];
                        cancel      <= 1'b0;
                        src         <= src_start;
                        dst_off     <= {dst_hi, dst_lo, 4'b0};
                        byte_cnt    <= '0;
                        busy        <= 1'b1;
                        if (reg_wdata[7]) begin
                            state <= HB_WAIT;
                        end else begin
                            state           <= READ;
                            dma_addr        <= src_start;
                            dma_re          <= 1'b1;
                            cpu_mem_disable <= 1'b1;
                        end
                    end
                end
                HB_WAIT: begin
                    if (cancel_req) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (hb_rise) begin
                        state           <= READ;
                        dma_addr        <= src;
                        dma_re          <= 1'b1;
                        cpu_mem_disable <= 1'b1;
                    end
                end
                READ: begin
                    if (cancel_req) cancel <= 1'b1;
                    state     <= WRITE;
                    dma_addr  <= dst_addr;
                    dma_wdata <= dma_rdata;
                    dma_re    <= 1'b0;
                    dma_we    <= 1'b1;
                end
                WRITE: begin
                    src       <= src_next;
                    dst_off   <= dst_off + 13'd1;
                    byte_cnt  <= byte_cnt + 1'b1;
                    dma_we    <= 1'b0;
                    dma_wdata <= '0;
                    if (!last_byte) begin
                        if (cancel_req) cancel <= 1'b1;
                        state    <= READ;
                        dma_addr <= src_next;
                        dma_re   <= 1'b1;
                    end else if (blocks_left == 7'd0 || cancel || cancel_req) begin
                        if (blocks_left == 7'd0) blocks_left <= '1;
                        state           <= IDLE;
                        dma_addr        <= '0;
                        cpu_mem_disable <= 1'b0;
                        busy            <= 1'b0;
                    end else begin
                        blocks_left <= blocks_left - 7'd1;
                        if (mode) begin
                            state           <= HB_WAIT;
                            dma_addr        <= '0;
                            cpu_mem_disable <= 1'b0;
                        end else begin
                            state    <= READ;
                            dma_addr <= src_next;
                            dma_re   <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hdma_engine.sv
// Self-checking bench for hdma_engine: random memory image, directed transfer scenarios,
// expected write streams computed from source/destination address arithmetic.
module tb_hdma_engine;
    localparam logic [15:0] RB = 16'hFF51;

    logic        clock;
    logic        reset;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_re;
    logic        reg_we;
    logic [7:0]  reg_rdata;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_re;
    logic        dma_we;
    logic [7:0]  dma_rdata;
    logic        hblank;
    logic        cpu_mem_disable;
    logic        busy;

    hdma_engine #(.BLOCK_BYTES(16), .REG_BASE(16'hFF51), .DST_BASE(16'h8000)) dut (
        .clock(clock), .reset(reset),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_re(reg_re), .reg_we(reg_we),
        .reg_rdata(reg_rdata),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_re(dma_re), .dma_we(dma_we),
        .dma_rdata(dma_rdata), .hblank(hblank),
        .cpu_mem_disable(cpu_mem_disable), .busy(busy)
    );

    logic [7:0]  mem [0:65535];
    logic [23:0] wr_q[$];
    logic [23:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int busy_cnt = 0;
    int cmd_cnt = 0;
    int viol = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign dma_rdata = dma_re ? mem[dma_addr] : 8'h00;

    always @(negedge clock) begin
        if (dma_we) wr_q.push_back({dma_addr, dma_wdata});
        if (busy) busy_cnt++;
        if (cpu_mem_disable) cmd_cnt++;
        if ((cpu_mem_disable !== (dma_re | dma_we)) || (!busy && (dma_re | dma_we)) ||
            (!(dma_re | dma_we) && (dma_addr !== 16'h0 || dma_wdata !== 8'h00)))
            viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic wr_reg(input int off, input logic [7:0] d);
        reg_addr  = RB + 16'(off);
        reg_wdata = d;
        reg_we    = 1'b1;
        tick();
        reg_we    = 1'b0;
    endtask

    task automatic read_ctrl(output logic [7:0] v);
        reg_addr = RB + 16'd4;
        reg_re   = 1'b1;
        #1;
        v        = reg_rdata;
        reg_re   = 1'b0;
    endtask

    task automatic set_regs(input logic [7:0] sh, sl, dh, dl);
        wr_reg(0, sh);
        wr_reg(1, sl);
        wr_reg(2, dh);
        wr_reg(3, dl);
    endtask

    task automatic clear_obs();
        wr_q.delete();
        busy_cnt = 0;
        cmd_cnt  = 0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 32'(busy), 32'd0);
    endtask

    // Expected byte stream: consecutive source bytes, destination wrapping inside 8 KiB.
    task automatic cmp_transfer(input string tag, input logic [7:0] sh, sl, dh, dl, input int n);
        int unsigned s, d, sa, da;
        s = 32'({sh, sl[7:4], 4'h0});
        d = 32'({dh[4:0], dl[7:4], 4'h0});
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            sa = (s + 32'(k)) % 65536;
            da = 32'h8000 + ((d + 32'(k)) % 8192);
            exp_q.push_back({16'(da), mem[16'(sa)]});
        end
        check({tag, "_len"}, 32'(wr_q.size()), 32'(n));
        for (int i = 0; i < n && i < wr_q.size(); i++)
            check({tag, "_wr"}, 32'(wr_q[i]), 32'(exp_q[i]));
    endtask

    task automatic hb_pulse(input int settle);
        hblank = 1'b0;
        tick();
        tick();
        hblank = 1'b1;
        repeat (settle) tick();
    endtask

    logic [7:0] sh, sl, dh, dl, rv;

    initial begin
        reset = 1'b0; reg_addr = '0; reg_wdata = '0; reg_re = 1'b0; reg_we = 1'b0; hblank = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(dma_we), 32'd0);
        check("rst_cmd", 32'(cpu_mem_disable), 32'd0);
        reset = 1'b1;
        tick();
        read_ctrl(rv);
        check("rst_ctrl", 32'(rv), 32'hFF);

        // single general block
        set_regs(8'h12, 8'h30, 8'h00, 8'h00);
        clear_obs();
        wr_reg(4, 8'h00);
        wait_idle("gen1", 200);
        check("gen1_busy_cycles", 32'(busy_cnt), 32'd32);
        cmp_transfer("gen1", 8'h12, 8'h30, 8'h00, 8'h00, 16);
        read_ctrl(rv);
        check("gen1_ctrl", 32'(rv), 32'hFF);

        // three general blocks, random addresses
        sh = 8'($urandom); sl = 8'($urandom); dh = 8'($urandom); dl = 8'($urandom);
        set_regs(sh, sl, dh, dl);
        clear_obs();
        wr_reg(4, 8'h02);
        wait_idle("gen3", 400);
        check("gen3_busy_cycles", 32'(busy_cnt), 32'd96);
        check("gen3_cmd_cycles", 32'(cmd_cnt), 32'd96);
        cmp_transfer("gen3", sh, sl, dh, dl, 48);

        // hblank mode, level already high at the CTRL write
        sh = 8'($urandom); sl = 8'($urandom); dh = 8'($urandom); dl = 8'($urandom);
        set_regs(sh, sl, dh, dl);
        clear_obs();
        hblank = 1'b1;
        wr_reg(4, 8'h81);
        repeat (10) tick();
        check("hb_held_nowr", 32'(wr_q.size()), 32'd0);
        read_ctrl(rv);
        check("hb_wait_ctrl", 32'(rv), 32'h01);
        hb_pulse(40);
        check("hb_blk1_len", 32'(wr_q.size()), 32'd16);
        read_ctrl(rv);
        check("hb_between_ctrl", 32'(rv), 32'h00);
        repeat (10) tick();
        check("hb_held_again", 32'(wr_q.size()), 32'd16);
        hb_pulse(0);
        wait_idle("hb", 200);
        cmp_transfer("hb", sh, sl, dh, dl, 32);
        read_ctrl(rv);
        check("hb_end_ctrl", 32'(rv), 32'hFF);

        // cancel while waiting for hblank
        sh = 8'($urandom); sl = 8'($urandom); dh = 8'($urandom); dl = 8'($urandom);
        set_regs(sh, sl, dh, dl);
        clear_obs();
        hblank = 1'b0;
        wr_reg(4, 8'h85);
        hb_pulse(40);
        hb_pulse(40);
        wr_reg(4, 8'h00);
        check("cancel_idle_next", 32'(busy), 32'd0);
        read_ctrl(rv);
        check("cancel_ctrl", 32'(rv), 32'h83);
        cmp_transfer("cancel", sh, sl, dh, dl, 32);

        // cancel in the middle of a block finishes that block
        sh = 8'($urandom); sl = 8'($urandom); dh = 8'($urandom); dl = 8'($urandom);
        set_regs(sh, sl, dh, dl);
        clear_obs();
        hblank = 1'b0;
        wr_reg(4, 8'h83);
        hb_pulse(5);
        wr_reg(4, 8'h00);
        check("midcancel_busy", 32'(busy), 32'd1);
        wait_idle("midcancel", 200);
        cmp_transfer("midcancel", sh, sl, dh, dl, 16);
        read_ctrl(rv);
        check("midcancel_ctrl", 32'(rv), 32'h83);
        hblank = 1'b0;

        // low nibbles ignored, destination wraps inside the window
        sh = 8'($urandom);
        set_regs(sh, 8'h3F, 8'hFF, 8'hF0);
        clear_obs();
        wr_reg(4, 8'h01);
        wait_idle("wrap", 300);
        cmp_transfer("wrap", sh, 8'h3F, 8'hFF, 8'hF0, 32);
        if (wr_q.size() > 16) check("wrap_first_after", 32'(wr_q[16][23:8]), 32'h8000);

        // reset during the fifth write
        sh = 8'($urandom); sl = 8'($urandom); dh = 8'($urandom); dl = 8'($urandom);
        set_regs(sh, sl, dh, dl);
        clear_obs();
        wr_reg(4, 8'h00);
        for (int i = 0; i < 100 && wr_q.size() < 5; i++) tick();
        check("rstmid_reached", 32'(wr_q.size()), 32'd5);
        reset = 1'b0;
        tick();
        check("rstmid_we", 32'(dma_we), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        read_ctrl(rv);
        check("rstmid_ctrl", 32'(rv), 32'hFF);
        repeat (10) tick();
        cmp_transfer("rstmid", sh, sl, dh, dl, 5);
        sh = 8'($urandom); sl = 8'($urandom); dh = 8'($urandom); dl = 8'($urandom);
        set_regs(sh, sl, dh, dl);
        clear_obs();
        wr_reg(4, 8'h00);
        wait_idle("restart", 200);
        cmp_transfer("restart", sh, sl, dh, dl, 16);
        check("restart_busy_cycles", 32'(busy_cnt), 32'd32);

        check("bus_protocol", 32'(viol), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
